// File: rtl/reg_file.sv
// reg_file: ARM-style register file, R0..R14 in flops plus r15 (PC+8) passthrough on address 15.
// Latency: reads are combinational (zero cycles); writes land on the rising clk edge.
// Backpressure: none; a write is accepted every cycle that we3 is high and reset is low.
//
// Ports:
//   clk        - write clock (rising edge)
//   reset      - asynchronous, active-high; clears R0..R14 and blocks writes while high
//   we3/wa3/wd3 - write port 3: enable, address, data
//   ra1/ra2    - read addresses for ports 1 and 2
//   r15        - externally supplied PC+8, returned for reads of the all-ones address
//   rd1/rd2    - read data for ports 1 and 2
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    input  logic [WIDTH-1:0]  r15,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2
);

    // The all-ones address is the PC, not storage, so depth is one short of 2^ADDR_W.
    localparam int DEPTH = (1 << ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] PC_ADDR = {ADDR_W{1'b1}};

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    // Writes aimed at the PC address are dropped; the PC is owned by the fetch stage.
    logic wr_en;
    assign wr_en = we3 && (wa3 != PC_ADDR);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wa3] = wd3;
        end
    end

    // Reset takes priority over a coincident edge, so no write can slip in while it is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // No write bypass: a read in the write cycle sees the old contents until the edge.
    always_comb begin
        rd1 = r15;
        if (ra1 != PC_ADDR) begin
            rd1 = regs_q[ra1];
        end
    end

    always_comb begin
        rd2 = r15;
        if (ra2 != PC_ADDR) begin
            rd2 = regs_q[ra2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized and directed stimulus for reg_file against an array-based model.
// Latency: expected read data is queued at each sample point and popped by an independent monitor.
// Backpressure: not applicable; the monitor consumes one entry per sample event.
module tb_reg_file;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              we3;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wa3;
    logic [WIDTH-1:0]  wd3;
    logic [WIDTH-1:0]  r15;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;

    reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .r15   (r15),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    event smp_ev;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: 15 general registers; address 15 reads r15.
    logic [WIDTH-1:0] model [15];

    function automatic logic [WIDTH-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (a == 4'd15) return r15;
        return model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 15; i++) model[i] = '0;
    endtask

    // Present read addresses, let the combinational path settle, then queue the expectation.
    task automatic check(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2, input string name);
        exp_t e;
        ra1 = a1;
        ra2 = a2;
        #1;
        e.e1   = ref_rd(a1);
        e.e2   = ref_rd(a2);
        e.name = name;
        exp_q.push_back(e);
        -> smp_ev;
        #1;
    endtask

    // Drive a write on the falling edge, commit it at the rising edge, update the model if legal.
    task automatic do_write(input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
        @(negedge clk);
        we3 = we;
        wa3 = wa;
        wd3 = wd;
        @(posedge clk);
        if (we && !reset && wa != 4'd15) model[wa] = wd;
        #1;
        we3 = 1'b0;
    endtask

    // Monitor: pops one expectation per sample event and compares both read ports.
    initial begin
        exp_t e;
        forever begin
            @(smp_ev);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL %s: sample with no queued expectation rd1=%h rd2=%h", "monitor", rd1, rd2);
            end else begin
                e = exp_q.pop_front();
                n_chk++;
                if (rd1 === e.e1) n_pass++;
                else $display("FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1);
                n_chk++;
                if (rd2 === e.e2) n_pass++;
                else $display("FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2);
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;

        reset = 1'b1;
        we3   = 1'b0;
        wa3   = '0;
        wd3   = '0;
        ra1   = '0;
        ra2   = '0;
        r15   = 32'h0000_0008;
        model_clear();

        // Reset clears storage; a write attempted under reset is blocked.
        #7;
        check(4'd0, 4'd14, "reset_r0_r14");
        do_write(1'b1, 4'd4, 32'h1111_2222);
        check(4'd4, 4'd15, "write_during_reset");
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check(4'd0, 4'd14, "post_reset_idle");

        // Basic write/read.
        do_write(1'b1, 4'd0, 32'hA5A5_A5A5);
        do_write(1'b1, 4'd1, 32'h1234_5678);
        check(4'd0, 4'd1, "basic_rw");

        // r15 path is combinational.
        r15 = 32'hFF00_FF00;
        check(4'd15, 4'd15, "r15_a");
        r15 = 32'h0000_0008;
        check(4'd15, 4'd0, "r15_b");

        // Write to address 15 is ignored.
        do_write(1'b1, 4'd15, 32'hDEAD_BEEF);
        check(4'd15, 4'd1, "wr15_ignored");
        for (int i = 0; i < 15; i += 2) check(4'(i), 4'(i + 1), "wr15_regs");

        // Read-during-write: old value before the edge, new value after.
        do_write(1'b1, 4'd2, 32'h8765_4321);
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 4'd2;
        wd3 = 32'hDEAD_BEEF;
        check(4'd2, 4'd2, "rdw_before");
        @(posedge clk);
        model[2] = 32'hDEAD_BEEF;
        #1;
        check(4'd2, 4'd0, "rdw_after");
        we3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wd3 = $urandom;
            wa3 = 4'd2;
            @(posedge clk);
            #1;
            check(4'd2, 4'd1, "we0_hold");
        end

        // Async reset between edges, plus a write attempted on an edge while reset is high.
        do_write(1'b1, 4'd3, 32'hDEAD_BEEF);
        check(4'd0, 4'd3, "r3_loaded");
        @(negedge clk);
        #1 reset = 1'b1;
        model_clear();
        check(4'd1, 4'd3, "async_reset");
        we3 = 1'b1;
        wa3 = 4'd3;
        wd3 = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        we3 = 1'b0;
        check(4'd15, 4'd3, "write_under_reset");
        @(negedge clk);
        #2 reset = 1'b0;

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 24) == 0) begin
                @(negedge clk);
                #($urandom_range(1, 3)) reset = 1'b1;
                model_clear();
                check(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd_reset");
                do_write(1'b1, 4'($urandom_range(0, 14)), $urandom);
                @(negedge clk);
                #2 reset = 1'b0;
            end else begin
                do_write($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom);
            end
            if ($urandom_range(0, 3) == 0) r15 = $urandom;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            check(a, b, "rnd_read");
        end

        // Full sweep of the final state.
        for (int i = 0; i < 16; i += 2) check(4'(i), 4'(i + 1), "final_sweep");

        // Give the monitor a bounded window to drain.
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- ARM-style general-purpose register file for the single-cycle processor datapath.
- Two combinational read ports and one synchronous write port.
- Holds R0..R14 (15 entries). Address 15 is not storage: it reads the externally supplied PC+8 value on port r15.
- Sits between instruction decode and the ALU; the write-back path drives the write port.

Parameters:
- WIDTH, 32, data width of every register and data port.
- ADDR_W, 4, register address width. Storage depth is 2^ADDR_W - 1. The all-ones address maps to r15.

Ports:
- clk  input  1  clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high; clears all stored registers.
- we3  input  1  write enable for port 3.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- wa3  input  ADDR_W  write address, port 3.
- wd3  input  WIDTH  write data, port 3.
- r15  input  WIDTH  PC+8 value, returned when address 15 is read.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: R0..R14, each WIDTH bits, all flops.
- Reset:
  - reset=1 immediately (asynchronously) sets R0..R14 to 0, independent of clk.
  - While reset is high, writes are blocked.
  - The outputs are not registered. During reset, rd1/rd2 read 0 for addresses 0..14 and r15 for address 15.
- Write:
  - On a rising clk edge with reset=0, we3=1 and wa3 != 15, R[wa3] <= wd3.
  - wa3 == 15 with we3=1: the write is silently ignored; no storage changes. The PC is written elsewhere.
  - we3=0: no register changes. wd3 and wa3 are don't-care.
- Read:
  - Purely combinational, zero latency: rd1 = (ra1==15) ? r15 : R[ra1], and likewise rd2 for ra2.
  - A change of r15 propagates immediately to any port addressing 15.
  - Both ports may address the same register at once; each returns the same value.
- Read-during-write: no bypass.
  - In the cycle a write is pending, a read of the same address returns the old contents.
  - The new value becomes visible just after the rising edge, within the same cycle's combinational settle.
- Reset released mid-cycle: the first write takes effect on the next rising edge where reset=0 is sampled.
  - Reset asserted coincident with an edge wins: no write occurs.
- No X propagation from storage after reset. Reading before any reset is undefined and not required.
- Width rules: no sign or zero extension; data passes through bit-exact.

Test Plan:
- Reset clears storage: assert reset, set ra1=0 and ra2=14 -> rd1=0, rd2=0. Release reset, no writes -> values stay 0.
- Basic write/read:
  - we3=1, wa3=0, wd3=A5A5A5A5, one edge.
  - Then wa3=1, wd3=12345678, one edge.
  - ra1=0, ra2=1 -> rd1=A5A5A5A5, rd2=12345678.
- r15 path: ra1=15, r15=FF00FF00 -> rd1=FF00FF00 with no clock edge. Change r15 to 00000008 -> rd1 follows combinationally.
- Write to 15 ignored:
  - we3=1, wa3=15, wd3=DEADBEEF, edge.
  - ra1=15 -> rd1 equals current r15, not DEADBEEF.
  - All of R0..R14 are unchanged.
- Read-during-write:
  - R2=87654321, ra1=2, we3=1, wa3=2, wd3=DEADBEEF.
  - Before the edge, rd1=87654321. After the edge, rd1=DEADBEEF.
  - we3=0 with wd3 changing -> rd1 holds DEADBEEF.
- Async reset mid-operation:
  - R3=DEADBEEF, ra2=3.
  - Pulse reset between clock edges -> rd2=0 immediately, without waiting for a clk edge.
  - A write attempted on an edge while reset=1 has no effect.
